// File: rtl/dm_burst_seq.sv
// dm_burst_seq: resolves a burst base address through the data-memory LUT, then issues a req/ack burst.
// Latency: start -> LUT lookup (1 cycle) -> first req; 1 access/cycle with ack high; done one cycle after the last ack.
// Backpressure: req/adr/we hold stable while dm_ack_i is low; start_i is only accepted in IDLE (no queuing).
// Optional build macro DM_BOUNDS_EN: abort (done_o + err_o) when a mid-burst address step wraps past 2^AW.
module dm_burst_seq #(
  parameter int AW = 8,
  parameter int PW = 5,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [PW-1:0] ptr_i,
  input  logic [LW-1:0] len_i,
  input  logic [AW-1:0] stride_i,
  input  logic          write_i,
  output logic [PW-1:0] lut_ptr_o,
  input  logic [AW-1:0] lut_dm_i,
  output logic [AW-1:0] dm_adr_o,
  output logic          dm_req_o,
  output logic          dm_we_o,
  input  logic          dm_ack_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_REQ    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] ptr_q;
  logic [LW-1:0] rem_q;      // accesses still to be acknowledged
  logic [AW-1:0] stride_q;
  logic [AW-1:0] adr_q;
  logic          we_q;
  logic          err_q;      // current DONE was reached by an abort

  logic [AW-1:0] adr_nxt;
  logic          abort;

`ifdef DM_BOUNDS_EN
  // One extra bit exposes the carry out of the address step; a carry on the
  // final ack is harmless because no further access uses that address.
  logic [AW:0] adr_sum;
  assign adr_sum = {1'b0, adr_q} + {1'b0, stride_q};
  assign adr_nxt = adr_sum[AW-1:0];
  assign abort   = adr_sum[AW] && (rem_q != LW'(1));
`else
  assign adr_nxt = adr_q + stride_q;
  assign abort   = 1'b0;
`endif

  // Burst sequencer: latch request, resolve base via LUT, step through accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      stride_q <= '0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (start_i) begin
            ptr_q    <= ptr_i;
            rem_q    <= len_i;
            stride_q <= stride_i;
            we_q     <= write_i;
            state    <= (len_i == '0) ? S_DONE : S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          adr_q <= lut_dm_i;
          state <= S_REQ;
        end
        S_REQ: begin
          if (dm_ack_i) begin
            rem_q <= rem_q - LW'(1);
            adr_q <= adr_nxt;
            if (rem_q == LW'(1)) begin
              state <= S_DONE;
            end else if (abort) begin
              err_q <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from state so req/adr/we stay stable across ack stalls.
  assign lut_ptr_o = (state == S_IDLE) ? '0 : ptr_q;
  assign dm_adr_o  = adr_q;
  assign dm_req_o  = (state == S_REQ);
  assign dm_we_o   = (state == S_REQ) && we_q;
  assign busy_o    = (state == S_LOOKUP) || (state == S_REQ);
  assign done_o    = (state == S_DONE);
  assign err_o     = (state == S_DONE) && err_q;

endmodule

// File: tb/tb_dm_burst_seq.sv
// Bench for dm_burst_seq: randomized bursts and ack stalls checked against a
// burst-level reference model (expected address list, access count, abort flag).
module tb_dm_burst_seq;
  localparam int AW = 8;
  localparam int PW = 5;
  localparam int LW = 8;
`ifdef DM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [PW-1:0] ptr_i;
  logic [LW-1:0] len_i;
  logic [AW-1:0] stride_i;
  logic          write_i;
  logic [PW-1:0] lut_ptr_o;
  logic [AW-1:0] lut_dm_i;
  logic [AW-1:0] dm_adr_o;
  logic          dm_req_o;
  logic          dm_we_o;
  logic          dm_ack_i;
  logic          busy_o;
  logic          done_o;
  logic          err_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dm_burst_seq #(.AW(AW), .PW(PW), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .ptr_i(ptr_i), .len_i(len_i),
    .stride_i(stride_i), .write_i(write_i), .lut_ptr_o(lut_ptr_o), .lut_dm_i(lut_dm_i),
    .dm_adr_o(dm_adr_o), .dm_req_o(dm_req_o), .dm_we_o(dm_we_o), .dm_ack_i(dm_ack_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  // Address LUT model: fixed entries 0..5, arbitrary pattern elsewhere.
  function automatic logic [AW-1:0] lut_model(input logic [PW-1:0] p);
    case (p)
      5'd0:    lut_model = 8'd14;
      5'd1:    lut_model = 8'd20;
      5'd2:    lut_model = 8'd127;
      5'd3:    lut_model = 8'd0;
      5'd4:    lut_model = 8'd15;
      5'd5:    lut_model = 8'd5;
      default: lut_model = 8'((int'(p) * 37 + 3) % 256);
    endcase
  endfunction

  assign lut_dm_i = lut_model(lut_ptr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req"},  dm_req_o,  0);
    check({tag, "_we"},   dm_we_o,   0);
    check({tag, "_busy"}, busy_o,    0);
    check({tag, "_done"}, done_o,    0);
    check({tag, "_err"},  err_o,     0);
    check({tag, "_ptr"},  lut_ptr_o, 0);
  endtask

  task automatic poke_start();
    start_i  = 1'b1;
    ptr_i    = PW'($urandom);
    len_i    = LW'($urandom_range(1, 9));
    stride_i = AW'($urandom);
    write_i  = ~write_i;
  endtask

  // Runs one burst; checks every cycle from the start edge until back in IDLE.
  task automatic run_burst(input int ptr, input int len, input int stride, input int wr,
                           input int pct, input int hold, input bit poke);
    int  exp_adr[$];
    int  exp_n;
    bit  exp_err;
    int  a;
    int  idx;
    int  cyc;
    bit  want_done;
    bit  fin;

    // Reference: list of addresses the memory should accept, possible abort.
    exp_adr.delete();
    exp_err = 1'b0;
    exp_n   = len;
    a       = int'(lut_model(PW'(ptr)));
    for (int k = 0; k < len; k++) begin
      exp_adr.push_back(a);
      if (BOUNDS && (k + 1 < len) && (a + stride > 255)) begin
        exp_err = 1'b1;
        exp_n   = k + 1;
        break;
      end
      a = (a + stride) % 256;
    end

    @(negedge clk);
    start_i  = 1'b1;
    ptr_i    = PW'(ptr);
    len_i    = LW'(len);
    stride_i = AW'(stride);
    write_i  = wr[0];
    dm_ack_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    start_i  = 1'b0;
    ptr_i    = PW'($urandom);
    len_i    = LW'($urandom);
    stride_i = AW'($urandom);

    idx       = 0;
    want_done = (len == 0);
    fin       = 1'b0;
    for (cyc = 1; cyc < 300 && !fin; cyc++) begin
      if (cyc > 1) @(negedge clk);
      start_i = 1'b0;
      check("done", done_o, want_done);
      check("err",  err_o,  want_done & exp_err);
      check("busy", busy_o, !want_done);
      check("req",  dm_req_o, !want_done && cyc >= 2);
      if (!want_done) check("lut_ptr", lut_ptr_o, ptr);
      if (!dm_req_o) check("we_noreq", dm_we_o, 0);
      dm_ack_i = 1'($urandom_range(0, 1));
      if (dm_req_o && idx < exp_n) begin
        check("adr", dm_adr_o, exp_adr[idx]);
        check("we",  dm_we_o,  wr);
        if (hold > 0) begin
          dm_ack_i = 1'b0;
          hold--;
        end else begin
          dm_ack_i = ($urandom_range(1, 100) <= pct);
        end
        if (dm_ack_i) idx++;
      end
      if (want_done) begin
        fin = 1'b1;
        if (poke) poke_start();
      end else if (dm_req_o && dm_ack_i && idx == exp_n) begin
        want_done = 1'b1;
      end else if (poke && dm_req_o && $urandom_range(0, 2) == 0) begin
        poke_start();
      end
    end
    check("burst_finished", fin, 1);
    check("access_count", idx, exp_n);

    @(negedge clk);
    start_i  = 1'b0;
    dm_ack_i = 1'b0;
    check_idle("post");
  endtask

  initial begin
    reset    = 1'b1;
    start_i  = 1'b1;
    ptr_i    = 5'd3;
    len_i    = 8'd4;
    stride_i = 8'd1;
    write_i  = 1'b1;
    dm_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_adr", dm_adr_o, 0);
    reset   = 1'b0;
    start_i = 1'b0;
    dm_ack_i = 1'b0;
    @(negedge clk);
    check_idle("rst_rel");

    run_burst(0, 3, 1,   0, 100, 0, 1'b0);   // back-to-back loads
    run_burst(4, 2, 5,   1, 100, 3, 1'b0);   // store with 3-cycle ack stall
    run_burst(2, 2, 200, 0, 100, 0, 1'b0);   // address wraps mid-burst
    run_burst(5, 0, 7,   0, 100, 0, 1'b0);   // zero-length burst
    run_burst(1, 4, 9,   1, 60,  1, 1'b1);   // start pulses while busy/done

    // Reset while a request is outstanding.
    @(negedge clk);
    start_i  = 1'b1;
    ptr_i    = 5'd1;
    len_i    = 8'd4;
    stride_i = 8'd3;
    write_i  = 1'b1;
    dm_ack_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("mid_req", dm_req_o, 1);
    check("mid_adr", dm_adr_o, 20);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_rst");
    reset = 1'b0;
    run_burst(3, 3, 255, 0, 100, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_burst($urandom_range(0, 31), ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 7),
                $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(30, 100),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dm_burst_seq.md
Name: dm_burst_seq

Overview:
- Controller that sequences data-memory accesses through the data-memory address lookup table.
- Takes a short LUT pointer plus burst length and stride, and resolves the base address through the LUT.
- Then issues a req/ack-handshaked burst of load or store addresses to data memory.
- Sits between instruction decode/control and the data memory address port, so one instruction can drive a multi-word access.

Parameters:
AW, 8, data memory address width (LUT output width)
PW, 5, LUT pointer width
LW, 8, burst length counter width

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start_i  input  1  one-cycle burst request; sampled only in IDLE
ptr_i  input  PW  LUT pointer selecting burst base address
len_i  input  LW  number of accesses in burst (0 allowed)
stride_i  input  AW  address increment between accesses, unsigned
write_i  input  1  1 = store burst, 0 = load burst
lut_ptr_o  output  PW  pointer driven to the address LUT
lut_dm_i  input  AW  base address returned by the LUT (combinational)
dm_adr_o  output  AW  current data memory address
dm_req_o  output  1  access request, valid with dm_adr_o/dm_we_o
dm_we_o  output  1  write enable qualifying dm_req_o
dm_ack_i  input  1  memory accepted the current request
busy_o  output  1  burst in progress
done_o  output  1  one-cycle burst completion pulse
err_o  output  1  one-cycle abort flag, coincident with done_o

Behaviour:
- Reset (synchronous, wins over all other inputs): state IDLE; all outputs 0, including lut_ptr_o and dm_adr_o. Internal len/stride/write registers cleared.
- States: IDLE, LOOKUP, REQ, DONE.
- IDLE:
  - On start_i, latch ptr_i, len_i, stride_i and write_i.
  - If len_i == 0, go to DONE with no memory access; otherwise go to LOOKUP.
- LOOKUP (exactly 1 cycle):
  - lut_ptr_o = latched ptr.
  - Register lut_dm_i into the address register, then go to REQ.
  - lut_ptr_o holds the latched ptr from LOOKUP through DONE and returns to 0 in IDLE.
- REQ:
  - dm_req_o = 1, dm_adr_o = address register, dm_we_o = latched write.
  - All three outputs hold stable until dm_ack_i = 1.
  - On ack: remaining count decrements; address becomes (address + stride) mod 2^AW.
  - If remaining reaches 0, go to DONE. Otherwise stay in REQ with req held high, so back-to-back accesses at 1 per cycle are possible with ack tied high.
- DONE (1 cycle): done_o = 1, dm_req_o = 0, then return to IDLE.
- busy_o = 1 in LOOKUP and REQ; 0 in IDLE and DONE.
- dm_we_o = 0 whenever dm_req_o = 0.
- dm_ack_i is ignored outside REQ.
- start_i is ignored in every state except IDLE, including DONE; no queuing.
- Timing: with start_i at edge 0 and ack tied high, the first req is visible in cycle 2, the last in cycle len+1, and done_o in cycle len+2.
- Reset asserted mid-burst: at the next edge the block is in IDLE with req/busy/done/err all 0. The outstanding access is abandoned.

Optional Feature:
- Macro: DM_BOUNDS_EN.
- Defined:
  - On an ack where remaining stays > 0 and address + stride carries out of AW bits, the burst aborts.
  - Go to DONE; done_o and err_o both pulse; no further req is issued.
  - An overflow on the final ack is not an error.
- Undefined: addresses wrap silently mod 2^AW; err_o tied 0.

Test Plan:
- Bench LUT model: 0→14, 1→20, 2→127, 3→0, 4→15, 5→5.
- Scenario 1: ack tied 1; start ptr=0 len=3 stride=1 load -> dm_adr_o 14, 15, 16 with req high in cycles 2, 3, 4, dm_we_o=0; done_o in cycle 5 only; busy_o high in cycles 1-4.
- Scenario 2: ptr=4 len=2 stride=5 store; ack held low 3 cycles, then high -> req=1, adr=15, we=1 stable for 4 cycles, then adr=20 for 1 cycle, then done_o.
- Scenario 3: ptr=2 len=2 stride=200, ack tied 1 -> without macro: addresses 127 then 71, err_o=0. With DM_BOUNDS_EN: only 127 issued; done_o=err_o=1 in the following cycle.
- Scenario 4: start ptr=5 len=0 -> no req ever; done_o=1 in cycle 1; busy_o stays 0.
- Scenario 5: start during REQ and during DONE -> ignored, burst unchanged; reset asserted while req=1 -> next cycle req, busy, done and lut_ptr_o all 0; a new start then runs a clean burst.
